// File: rtl/ram256_wb_ctrl.sv
// Wishbone-classic slave front-end for the 256-word RAM256 macro.
// A request hitting the decoded window is registered onto the RAM port
// for one cycle. The macro's synchronous read is then waited out, and
// the controller answers with registered data and a single-cycle ack.
module ram256_wb_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_FC00,
  parameter int unsigned WSIZE     = 4
) (
  input  logic                 CLK,
  input  logic                 RESETn,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_we_i,
  input  logic [WSIZE-1:0]     wb_sel_i,
  input  logic [31:0]          wb_adr_i,
  input  logic [WSIZE*8-1:0]   wb_dat_i,
  output logic [WSIZE*8-1:0]   wb_dat_o,
  output logic                 wb_ack_o,
  output logic                 ram_EN0,
  output logic [WSIZE-1:0]     ram_WE0,
  output logic [7:0]           ram_A0,
  output logic [WSIZE*8-1:0]   ram_Di0,
  input  logic [WSIZE*8-1:0]   ram_Do0
);

  // IDLE waits for a hit, MEM is the cycle the macro samples EN0, RESP captures data/ack
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 ack_q, ack_d;
  logic [WSIZE*8-1:0]   dat_q, dat_d;
  logic                 en_q, en_d;
  logic [WSIZE-1:0]     we_q, we_d;
  logic [7:0]           a_q, a_d;
  logic [WSIZE*8-1:0]   di_q, di_d;
  // remembers whether the in-flight transaction is a write, independent of
  // the lane mask (a write with sel=0 must still leave wb_dat_o untouched)
  logic                 wr_q, wr_d;
  logic                 hit_s;

  assign hit_s = wb_cyc_i & wb_stb_i & ((wb_adr_i & ADDR_MASK) == BASE_ADDR);

  // Next-state and registered-output computation for the bus/RAM sequencer
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    dat_d   = dat_q;
    en_d    = en_q;
    we_d    = we_q;
    a_d     = a_q;
    di_d    = di_q;
    wr_d    = wr_q;
    case (state_q)
      IDLE: begin
        ack_d = 1'b0;
        if (hit_s) begin
          state_d = MEM;
          en_d    = 1'b1;
          a_d     = wb_adr_i[9:2];
          we_d    = wb_we_i ? wb_sel_i : {WSIZE{1'b0}};
          di_d    = wb_dat_i;
          wr_d    = wb_we_i;
        end else begin
          en_d    = 1'b0;
          we_d    = {WSIZE{1'b0}};
        end
      end
      MEM: begin
        // the macro performs the access on this edge; drop the enable so
        // EN0 is high for exactly one cycle, address stays held
        en_d    = 1'b0;
        we_d    = {WSIZE{1'b0}};
        ack_d   = 1'b0;
        state_d = RESP;
      end
      RESP: begin
        if (!wr_q) begin
          dat_d = ram_Do0;
        end else begin
          dat_d = dat_q;
        end
        // an aborted cycle still completes in the RAM but is never acked
        ack_d   = wb_cyc_i;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
        we_d    = {WSIZE{1'b0}};
        ack_d   = 1'b0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by RESETn
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      dat_q   <= {(WSIZE*8){1'b0}};
      en_q    <= 1'b0;
      we_q    <= {WSIZE{1'b0}};
      a_q     <= 8'h00;
      di_q    <= {(WSIZE*8){1'b0}};
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      en_q    <= en_d;
      we_q    <= we_d;
      a_q     <= a_d;
      di_q    <= di_d;
      wr_q    <= wr_d;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign ram_EN0  = en_q;
  assign ram_WE0  = we_q;
  assign ram_A0   = a_q;
  assign ram_Di0  = di_q;

endmodule
